// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state encoding, width and E-stage function codes for the divider.
package div_unit_pkg;
    localparam int DIV_WIDTH = 32;
    localparam logic [7:0] FUN_DIV  = 8'b0001_1010;
    localparam logic [7:0] FUN_DIVU = 8'b0001_1011;
    typedef enum logic [1:0] {
        DIV_FREE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring step on the partial remainder.
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    assign shifted = {rem_i, msb_i};
    // shifted < 2*divisor, so the top bit of the difference is a clean borrow
    assign trial = shifted - {1'b0, divisor_i};
    assign q_o   = ~trial[WIDTH];
    assign rem_o = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for DIV/DIVU with stall handshake.
// Define DIV_EARLY_OUT_EN to finish in 2 cycles when |dividend| < |divisor|.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter int ITER_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic               stall_div,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);
    localparam logic [ITER_W-1:0] LAST = ITER_W'(WIDTH - 1);

    div_state_e         state_q;
    logic [ITER_W-1:0]  cnt_q;
    logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
    logic               sa_q, sb_q, ready_q;
    logic [2*WIDTH-1:0] result_q;
    logic [WIDTH-1:0]   rem_d, quo_d, abs_a, abs_b, quo_fix_d, rem_fix_d;
    logic               q_bit;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return (s & v[WIDTH-1]) ? -v : v;
    endfunction

    assign abs_a = mag(opdata1, signed_div);
    assign abs_b = mag(opdata2, signed_div);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .msb_i     (quo_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (rem_d),
        .q_o       (q_bit)
    );

    assign quo_d     = {quo_q[WIDTH-2:0], q_bit};
    assign quo_fix_d = (sa_q ^ sb_q) ? -quo_d : quo_d;
    assign rem_fix_d = sa_q ? -rem_d : rem_d;

    assign stall_div = start & ~ready_q;
    assign ready     = ready_q;
    assign result    = result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else if (annul) begin
            state_q <= DIV_FREE;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                DIV_FREE: begin
                    ready_q <= 1'b0;
                    if (start) begin
                        if (opdata2 == '0) begin
                            state_q <= DIV_BYZERO;
                            rem_q   <= '0;
                            quo_q   <= '0;
                        end
`ifdef DIV_EARLY_OUT_EN
                        // short path reuses BYZERO so latency matches the divide-by-zero case
                        else if (abs_a < abs_b) begin
                            state_q <= DIV_BYZERO;
                            rem_q   <= opdata1;
                            quo_q   <= '0;
                        end
`endif
                        else begin
                            state_q <= DIV_ON;
                            rem_q   <= '0;
                            quo_q   <= abs_a;
                            dvs_q   <= abs_b;
                            cnt_q   <= '0;
                            sa_q    <= signed_div & opdata1[WIDTH-1];
                            sb_q    <= signed_div & opdata2[WIDTH-1];
                        end
                    end
                end
                DIV_BYZERO: begin
                    state_q  <= DIV_END;
                    ready_q  <= 1'b1;
                    result_q <= {rem_q, quo_q};
                end
                DIV_ON: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q  <= DIV_END;
                        ready_q  <= 1'b1;
                        result_q <= {rem_fix_d, quo_fix_d};
                    end
                end
                DIV_END: begin
                    state_q <= DIV_FREE;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= DIV_FREE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: vector table, hand sequences and random divides checked against an arithmetic model.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst, start, signed_div, annul;
    logic [31:0] opdata1, opdata2;
    logic        stall_div, ready;
    logic [63:0] result;
    int checks = 0;
    int errors = 0;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .stall_div  (stall_div),
        .ready      (ready),
        .result     (result)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] r;
    } vec_t;

    task automatic chk64(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", n, got, exp);
        end
    endtask

    task automatic chki(input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", n, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        x = s ? longint'($signed(a)) : longint'({32'd0, a});
        y = s ? longint'($signed(b)) : longint'({32'd0, b});
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'({32'd0, a});
        y = s ? longint'($signed(b)) : longint'({32'd0, b});
        if (x < 0) x = -x;
        if (y < 0) y = -y;
        if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
        if (x < y) return 2;
`endif
        return 33;
    endfunction

    // caller is just after a rising edge; returns just after the edge that follows the ready cycle
    task automatic do_div(input string n, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp_r, input int exp_lat);
        int cyc = 0;
        bit seen = 0;
        bit stall_bad = 0;
        start = 1'b1; signed_div = s; opdata1 = a; opdata2 = b;
        while (cyc <= 60 && !seen) begin
            @(negedge clk);
            if (ready) begin
                seen = 1;
                if (stall_div !== 1'b0) stall_bad = 1;
            end else if (stall_div !== 1'b1) stall_bad = 1;
            if (!seen) begin
                @(posedge clk); #1;
                cyc++;
                opdata1 = $urandom;
                opdata2 = $urandom;
            end
        end
        chki({n, " latency"}, seen ? cyc : -1, exp_lat);
        if (seen) chk64({n, " result"}, result, exp_r);
        chki({n, " stall"}, int'(stall_bad), 0);
        @(posedge clk); #1;
    endtask

    vec_t vecs[10];

    initial begin
        logic [31:0] a, b;
        logic        s;
        bit          pulsed;
        bit          held;
        vecs[0] = '{32'd100,        32'd7,          1'b0, 64'h00000002_0000000E};
        vecs[1] = '{32'hFFFFFFF9,   32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD};
        vecs[2] = '{32'd7,          32'hFFFFFFFE,   1'b1, 64'h00000001_FFFFFFFD};
        vecs[3] = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000};
        vecs[4] = '{32'd5,          32'd0,          1'b0, 64'h0};
        vecs[5] = '{32'd3,          32'd9,          1'b0, 64'h00000003_00000000};
        vecs[6] = '{32'hFFFFFFFD,   32'd9,          1'b1, 64'hFFFFFFFD_00000000};
        vecs[7] = '{32'hFFFFFFFF,   32'd1,          1'b0, 64'h00000000_FFFFFFFF};
        vecs[8] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'h00000000_00000001};
        vecs[9] = '{32'd5,          32'd0,          1'b1, 64'h0};

        rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
        opdata1 = '0; opdata2 = '0;
        @(negedge clk);
        chki("reset ready", int'(ready), 0);
        chk64("reset result", result, 64'd0);
        chki("reset stall", int'(stall_div), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            do_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r,
                   model_lat(vecs[i].a, vecs[i].b, vecs[i].s));
            start = 1'b0;
            @(posedge clk); #1;
        end

        // annul mid-ON: no pulse, previous result kept, then a fresh divide runs full length
        do_div("pre_annul", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
        repeat (10) begin @(posedge clk); #1; end
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        pulsed = 0; held = 1;
        repeat (40) begin
            @(negedge clk);
            if (ready) pulsed = 1;
            if (result !== 64'h00000002_0000000E) held = 0;
        end
        chki("annul no ready", int'(pulsed), 0);
        chki("annul result held", int'(held), 1);
        @(posedge clk); #1;
        do_div("post_annul", 32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D, 33);
        start = 1'b0;
        @(posedge clk); #1;

        // asynchronous reset between clock edges
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd77; opdata2 = 32'd5;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b1; start = 1'b0;
        #1;
        chki("async rst ready", int'(ready), 0);
        chk64("async rst result", result, 64'd0);
        chki("async rst stall", int'(stall_div), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        do_div("post_rst", 32'd77, 32'd5, 1'b0, 64'h00000002_0000000F, 33);

        // back-to-back with start held across both
        do_div("b2b_first", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33);
        do_div("b2b_second", 32'd8, 32'd4, 1'b0, 64'h00000000_00000002, 33);
        start = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 30; k++) begin
            s = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFFFFFF;
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            do_div($sformatf("rand%0d", k), a, b, s, model(a, b, s), model_lat(a, b, s));
            if ($urandom_range(0, 1) == 0) begin
                start = 1'b0;
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
